// File: rtl/nlfsr_stream_checker.sv
// Streaming PRNG quality checker: per-window monobit count and a
// consecutive-repeat detector on 64-bit words.
module nlfsr_stream_checker #(
   parameter int unsigned WINDOW  = 15625,
   parameter int unsigned REP_MAX = 4,
   parameter int unsigned ONES_LO = 498000,
   parameter int unsigned ONES_HI = 502000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] data_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        mono_fail,
   output logic        rep_fail,
   output logic [31:0] ones_count,
   output logic [31:0] word_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_EVAL,
      S_DONE
   } state_t;

   state_t      state_q;
   logic        ready_q;
   logic        busy_q;
   logic        done_q;
   logic        pass_q;
   logic        mono_q;
   logic        rep_q;
   logic [31:0] ones_q;
   logic [31:0] wc_q;
   logic [31:0] run_q;
   logic [63:0] prev_q;

   logic [31:0] ones_d;
   logic [31:0] wc_d;
   logic [31:0] run_d;
   logic        accept;
   logic        rep_hit;
   logic        win_hit;
   logic        out_of_range;

   function automatic logic [6:0] popcnt64(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int b = 0; b < 64; b++) begin
         c = c + {6'd0, v[b]};
      end
      return c;
   endfunction

   always_comb begin
      accept  = ready_q && data_valid;
      ones_d  = ones_q + {25'd0, popcnt64(data_in)};
      wc_d    = wc_q + 32'd1;
      // The first word of a window always opens a fresh run
      if (wc_q == 32'd0) begin
         run_d = 32'd1;
      end else if (data_in == prev_q) begin
         run_d = run_q + 32'd1;
      end else begin
         run_d = 32'd1;
      end
      rep_hit      = (run_d == REP_MAX);
      win_hit      = (wc_d == WINDOW);
      out_of_range = (ones_q < ONES_LO) || (ones_q > ONES_HI);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mono_q  <= 1'b0;
         rep_q   <= 1'b0;
         ones_q  <= '0;
         wc_q    <= '0;
         run_q   <= '0;
         prev_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pass_q  <= 1'b0;
                  mono_q  <= 1'b0;
                  rep_q   <= 1'b0;
                  ones_q  <= '0;
                  wc_q    <= '0;
                  run_q   <= '0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  ones_q <= ones_d;
                  wc_q   <= wc_d;
                  run_q  <= run_d;
                  prev_q <= data_in;
                  if (rep_hit || win_hit) begin
                     rep_q   <= rep_hit;
                     ready_q <= 1'b0;
                     state_q <= S_EVAL;
                  end
                  end
            end
            S_EVAL: begin
               // An aborted window never reports a monobit verdict
               mono_q  <= !rep_q && out_of_range;
               pass_q  <= !rep_q && !out_of_range;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign data_ready = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign mono_fail  = mono_q;
   assign rep_fail   = rep_q;
   assign ones_count = ones_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_nlfsr_stream_checker.sv
// Bench for nlfsr_stream_checker: directed windows plus randomized
// windows checked against a word-list reference model.
module tb_nlfsr_stream_checker;

   localparam int W  = 4;
   localparam int RM = 3;
   localparam int LO = 96;
   localparam int HI = 160;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [63:0] data_in = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic        busy;
   logic        done;
   logic        pass;
   logic        mono_fail;
   logic        rep_fail;
   logic [31:0] ones_count;
   logic [31:0] word_count;

   int total = 0;
   int bad = 0;
   logic [63:0] wq[$];

   nlfsr_stream_checker #(
      .WINDOW (W),
      .REP_MAX(RM),
      .ONES_LO(LO),
      .ONES_HI(HI)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (data_in),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .mono_fail (mono_fail),
      .rep_fail  (rep_fail),
      .ones_count(ones_count),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   task automatic load_nominal();
      wq.delete();
      wq.push_back(64'hAAAA_AAAA_AAAA_AAAA);
      wq.push_back(64'h5555_5555_5555_5555);
      wq.push_back(64'hAAAA_AAAA_AAAA_AAAA);
      wq.push_back(64'h5555_5555_5555_5555);
   endtask

   task automatic check_all_zero(input string tag);
      total++;
      if (data_ready !== 0 || busy !== 0 || done !== 0 || pass !== 0 ||
          mono_fail !== 0 || rep_fail !== 0 || ones_count !== 0 ||
          word_count !== 0) begin
         bad++;
         $display("FAIL %s: rdy=%b busy=%b done=%b pass=%b mono=%b rep=%b ones=%0d words=%0d required all 0",
                  tag, data_ready, busy, done, pass, mono_fail, rep_fail,
                  ones_count, word_count);
      end
   endtask

   // mode 0: valid every cycle, 1: alternate cycles, 2: random
   task automatic run_window(input int mode, input string tag);
      int k, e_ones, streak, i, acc_ones, guard, n;
      bit e_rep, e_mono, e_pass, v, acc;
      logic h_pass, h_mono, h_rep;
      logic [31:0] h_ones, h_wc;
      k = 0; e_ones = 0; streak = 0; e_rep = 0;
      for (int j = 0; j < wq.size(); j++) begin
         e_ones += $countones(wq[j]);
         streak = (j > 0 && wq[j] == wq[j-1]) ? streak + 1 : 1;
         k = j + 1;
         if (streak == RM) begin
            e_rep = 1;
            break;
         end
         if (k == W) break;
      end
      e_mono = !e_rep && (e_ones < LO || e_ones > HI);
      e_pass = !e_rep && !e_mono;

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1 || data_ready !== 1 || ones_count !== 0 ||
          word_count !== 0) begin
         bad++;
         $display("FAIL %s_start: busy=%b rdy=%b ones=%0d words=%0d required 1 1 0 0",
                  tag, busy, data_ready, ones_count, word_count);
      end

      i = 0; acc_ones = 0; guard = 0;
      while (i < k && guard < 200) begin
         case (mode)
            0: v = 1;
            1: v = (guard % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         data_valid = v;
         data_in = v ? wq[i] : {$urandom, $urandom};
         acc = v && (data_ready === 1'b1);
         @(negedge clk);
         guard++;
         if (acc) begin
            acc_ones += $countones(wq[i]);
            i++;
         end
         total++;
         if (ones_count !== acc_ones || word_count !== i) begin
            bad++;
            $display("FAIL %s_count: ones=%0d words=%0d required %0d %0d",
                     tag, ones_count, word_count, acc_ones, i);
         end
      end
      data_valid = 1'b0;
      total++;
      if (guard >= 200) begin
         bad++;
         $display("FAIL %s_accept_timeout: accepted=%0d required %0d", tag, i, k);
      end

      total++;
      if (done !== 0 || busy !== 1 || data_ready !== 0) begin
         bad++;
         $display("FAIL %s_eval: done=%b busy=%b rdy=%b required 0 1 0",
                  tag, done, busy, data_ready);
      end
      n = 1;
      while (done !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n != 2) begin
         bad++;
         $display("FAIL %s_latency: done after %0d cycles required 2", tag, n);
      end
      total++;
      if (pass !== e_pass || mono_fail !== e_mono || rep_fail !== e_rep ||
          ones_count !== e_ones || word_count !== k) begin
         bad++;
         $display("FAIL %s_result: pass=%b mono=%b rep=%b ones=%0d words=%0d required %b %b %b %0d %0d",
                  tag, pass, mono_fail, rep_fail, ones_count, word_count,
                  e_pass, e_mono, e_rep, e_ones, k);
      end
      h_pass = pass; h_mono = mono_fail; h_rep = rep_fail;
      h_ones = ones_count; h_wc = word_count;

      @(negedge clk);
      total++;
      if (done !== 0 || busy !== 0 || data_ready !== 0) begin
         bad++;
         $display("FAIL %s_after_done: done=%b busy=%b rdy=%b required 0 0 0",
                  tag, done, busy, data_ready);
      end
      data_valid = 1'b1;
      data_in = {$urandom, $urandom};
      repeat (3) @(negedge clk);
      data_valid = 1'b0;
      total++;
      if (pass !== e_pass || mono_fail !== e_mono || rep_fail !== e_rep ||
          ones_count !== e_ones || word_count !== k || done !== 0) begin
         bad++;
         $display("FAIL %s_hold: pass=%b mono=%b rep=%b ones=%0d words=%0d done=%b required %b %b %b %0d %0d 0",
                  tag, pass, mono_fail, rep_fail, ones_count, word_count,
                  done, h_pass, h_mono, h_rep, h_ones, h_wc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_nominal();
      load_nominal();
      run_window(0, "nominal");
   endtask

   task automatic test_monobit_high();
      wq.delete();
      wq.push_back(64'hFFFF_FFFF_FFFF_FFFE);
      wq.push_back(64'hFFFF_FFFF_FFFF_FFFD);
      wq.push_back(64'hFFFF_FFFF_FFFF_FFFB);
      wq.push_back(64'hFFFF_FFFF_FFFF_FFF7);
      run_window(0, "mono_high");
   endtask

   task automatic test_repetition();
      wq.delete();
      repeat (6) wq.push_back(64'h0);
      run_window(0, "repeat");
   endtask

   task automatic test_gapped();
      load_nominal();
      run_window(1, "gapped");
   endtask

   task automatic test_start_busy_reset();
      load_nominal();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      data_valid = 1'b1;
      data_in = wq[0];
      @(negedge clk);
      data_in = wq[1];
      @(negedge clk);
      data_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (word_count !== 2 || ones_count !== 64 || busy !== 1 ||
          data_ready !== 1) begin
         bad++;
         $display("FAIL start_in_run: words=%0d ones=%0d busy=%b rdy=%b required 2 64 1 1",
                  word_count, ones_count, busy, data_ready);
      end
      #2 rst = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("idle_after_midrun_reset");
      run_window(0, "fresh");
   endtask

   task automatic test_random();
      int r;
      for (int t = 0; t < 30; t++) begin
         wq.delete();
         for (int j = 0; j < 6; j++) begin
            r = $urandom_range(0, 5);
            if (r == 0 && j > 0) wq.push_back(wq[j-1]);
            else if (r == 1) wq.push_back(64'h0);
            else if (r == 2) wq.push_back({64{1'b1}});
            else wq.push_back({$urandom, $urandom});
         end
         run_window($urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_monobit_high();
      test_repetition();
      test_gapped();
      test_start_busy_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nlfsr_stream_checker.md
NLFSR_STREAM_CHECKER -- requirements
Module: nlfsr_stream_checker

Interface
Parameters:
REQ-001 The block SHALL have parameter WINDOW, default 15625, meaning the number of 64-bit words per test window.
REQ-002 The block SHALL have parameter REP_MAX, default 4, meaning the count of consecutive identical accepted words that triggers a repetition failure; legal range is 2 or more.
REQ-003 The block SHALL have parameter ONES_LO, default 498000, meaning the minimum passing ones count per window, inclusive.
REQ-004 The block SHALL have parameter ONES_HI, default 502000, meaning the maximum passing ones count per window, inclusive.

Ports:
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: begins a test window when sampled high in IDLE.
REQ-008 The block SHALL have port data_in, input, 64 bits: the PRNG word under test.
REQ-009 The block SHALL have port data_valid, input, 1 bit: data_in is valid this cycle.
REQ-010 The block SHALL have port data_ready, output, 1 bit: the checker accepts a word this cycle.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN and EVAL.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-013 The block SHALL have port pass, output, 1 bit: the window passed both tests.
REQ-014 The block SHALL have port mono_fail, output, 1 bit: the ones count fell outside [ONES_LO, ONES_HI].
REQ-015 The block SHALL have port rep_fail, output, 1 bit: the repetition limit was hit.
REQ-016 The block SHALL have port ones_count, output, 32 bits: accumulated ones in the current or last window.
REQ-017 The block SHALL have port word_count, output, 32 bits: words accepted in the current or last window.

Function
REQ-018 The block SHALL implement FSM states IDLE, RUN, EVAL and DONE.
REQ-019 In IDLE, start=1 SHALL clear ones_count, word_count, pass, mono_fail, rep_fail and the repetition run counter, and SHALL move to RUN on the next edge; start SHALL be ignored in every other state.
REQ-020 data_ready SHALL be high only in RUN; a word is accepted on an edge where data_valid and data_ready are both 1; data_valid=0 cycles SHALL change no counters.
REQ-021 On acceptance, ones_count SHALL add popcount(data_in), 0 to 64, and word_count SHALL increment by 1; both update in the same cycle.
REQ-022 The repetition run SHALL be set to 1 on the first accepted word of a window; on each later word it SHALL increment if data_in equals the previously accepted word and reset to 1 otherwise.
REQ-023 When the repetition run reaches REP_MAX, rep_fail SHALL set and the FSM SHALL go to EVAL on the next edge; the window is aborted and mono_fail SHALL remain 0.
REQ-024 When the accepted word makes word_count equal WINDOW, the FSM SHALL go to EVAL on the next edge; if the repetition limit is hit on that same word, rep_fail SHALL take priority per REQ-023.
REQ-025 EVAL SHALL last one cycle: for a complete window, mono_fail = (ones_count < ONES_LO) or (ones_count > ONES_HI); pass = not mono_fail and not rep_fail, registered in EVAL.
REQ-026 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-027 Latency SHALL be fixed: last word accepted at cycle N, EVAL at N+1, done=1 at N+2.
REQ-028 pass, mono_fail, rep_fail, ones_count and word_count SHALL hold their values after DONE until the next accepted start.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, data_ready=0, busy=0, done=0, pass=0, mono_fail=0, rep_fail=0, ones_count=0, word_count=0 and the repetition run counter and previous-word register to 0, including mid-RUN or mid-EVAL.
REQ-030 After rst returns to 1, the block SHALL stay in IDLE until start is sampled high.

Verification
Bench parameters: WINDOW=4, REP_MAX=3, ONES_LO=96, ONES_HI=160.
REQ-031 Nominal: start; words AAAA_AAAA_AAAA_AAAA, 5555_5555_5555_5555, AAAA..., 5555... with valid high every cycle -> ones_count=128, word_count=4, pass=1, done exactly 2 cycles after 4th acceptance.
REQ-032 Monobit high: words FFFF_FFFF_FFFF_FFFE, ...FFFD, ...FFFB, ...FFF7 -> ones_count=252, mono_fail=1, rep_fail=0, pass=0.
REQ-033 Repetition: word 0 sent continuously -> rep_fail=1 after the 3rd acceptance, word_count=3, ones_count=0, mono_fail=0, pass=0, done at acceptance cycle +2.
REQ-034 Gapped valid: the REQ-031 words with data_valid low on alternate cycles -> identical results; counters unchanged on idle cycles.
REQ-035 Start while busy plus mid-run reset: pulse start in RUN -> no effect; assert rst=0 after 2 words -> all outputs 0 immediately; a fresh start with the REQ-031 sequence -> pass=1.
